sys_pll_clkgen: RTL and testbench



---
 rtl/sys_pll_clkgen.sv | 128 ++++++++++++
 tb/tb_sys_pll_clkgen.sv | 113 +++++++++++
 2 files changed

// File: rtl/sys_pll_clkgen.sv
// sys_pll_clkgen: digital stand-in for the system PLL. Holds its outputs low
// for LOCK_CYCLES reference edges after reset release, then asserts locked and
// starts four phase-aligned integer clock dividers off inclk0.

module sys_pll_clkgen_div #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic start_i,
  input  logic run_i,
  output logic clk_o
);

  localparam logic [15:0] LAST = 16'(DIV - 1);
  localparam logic [15:0] HIGH = 16'((DIV + 1) / 2);

  logic [15:0] cnt_q, cnt_d;
  logic        clk_q, clk_d;

  // Next count and output level; start forces the common rising edge.
  always_comb begin
    cnt_d = cnt_q;
    clk_d = clk_q;
    if (start_i) begin
      cnt_d = '0;
      clk_d = 1'b1;
    end else if (run_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 16'd1;
      clk_d = (cnt_d < HIGH);
    end
  end

  // Divider state register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk_o = clk_q;

endmodule

module sys_pll_clkgen #(
  parameter int DIV0        = 2,
  parameter int DIV1        = 4,
  parameter int DIV2        = 5,
  parameter int DIV3        = 50,
  parameter int LOCK_CYCLES = 16
) (
  input  logic inclk0,
  input  logic areset,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic locked
);

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  typedef enum logic {
    ST_LOCKING = 1'b0,
    ST_LOCKED  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic        locked_q;
  logic        start;
  logic        run;

  // Lock sequencing: count edges until the LOCK_CYCLES-th, then stay locked.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    start      = 1'b0;
    unique case (state_q)
      ST_LOCKING: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = ST_LOCKED;
          start   = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + 16'd1;
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      default: state_d = ST_LOCKING;
    endcase
  end

  // Lock state, counter and registered locked flag.
  always_ff @(posedge inclk0 or negedge areset) begin
    if (!areset) begin
      state_q    <= ST_LOCKING;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_q | start;
    end
  end

  assign run    = (state_q == ST_LOCKED);
  assign locked = locked_q;

  sys_pll_clkgen_div #(.DIV(DIV0)) u_div0 (
    .clk_i(inclk0), .rst_n(areset), .start_i(start), .run_i(run), .clk_o(c0)
  );
  sys_pll_clkgen_div #(.DIV(DIV1)) u_div1 (
    .clk_i(inclk0), .rst_n(areset), .start_i(start), .run_i(run), .clk_o(c1)
  );
  sys_pll_clkgen_div #(.DIV(DIV2)) u_div2 (
    .clk_i(inclk0), .rst_n(areset), .start_i(start), .run_i(run), .clk_o(c2)
  );
  sys_pll_clkgen_div #(.DIV(DIV3)) u_div3 (
    .clk_i(inclk0), .rst_n(areset), .start_i(start), .run_i(run), .clk_o(c3)
  );

endmodule

// File: tb/tb_sys_pll_clkgen.sv
// Directed bench for sys_pll_clkgen: default build plus a small override build.
module tb_sys_pll_clkgen;

  logic clk = 1'b0;
  logic areset  = 1'b0;
  logic areset2 = 1'b0;
  logic c0, c1, c2, c3, locked;
  logic d0, d1, d2, d3, dlocked;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  sys_pll_clkgen dut (
    .inclk0(clk), .areset(areset),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .locked(locked)
  );

  sys_pll_clkgen #(.DIV0(3), .DIV3(2), .LOCK_CYCLES(1)) dut2 (
    .inclk0(clk), .areset(areset2),
    .c0(d0), .c1(d1), .c2(d2), .c3(d3), .locked(dlocked)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected level n edges after the locking edge (n=0 is the locking edge).
  function automatic logic ref_clk(input int n, input int div);
    return (n % div) < ((div + 1) / 2);
  endfunction

  function automatic logic [3:0] ref_all(input int n, input int k0, input int k1,
                                         input int k2, input int k3);
    return {ref_clk(n, k3), ref_clk(n, k2), ref_clk(n, k1), ref_clk(n, k0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release dut reset and walk the 16-edge lock sequence.
  task automatic lock_seq(input string tag);
    @(negedge clk);
    areset = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      check({tag, "_prelock"}, {27'd0, c3, c2, c1, c0, locked}, 32'd0);
    end
    tick();
    check({tag, "_lockedge"}, {27'd0, c3, c2, c1, c0, locked}, 32'h1f);
  endtask

  initial begin
    // 1. power-on reset, 3 cycles
    #1;
    check("por_async", {27'd0, c3, c2, c1, c0, locked}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("por_hold", {27'd0, c3, c2, c1, c0, locked}, 32'd0);
    end
    lock_seq("pwrup");

    // 2. 200 cycles of running clocks
    for (int n = 1; n <= 200; n++) begin
      tick();
      check("run_clocks", {28'd0, c3, c2, c1, c0}, {28'd0, ref_all(n, 2, 4, 5, 50)});
      if (n == 99)  check("pre_realign", {28'd0, c3, c2, c1, c0}, 32'd0);
      if (n == 100) check("realign", {28'd0, c3, c2, c1, c0}, 32'hf);
    end
    check("locked_hold", {31'd0, locked}, 32'd1);

    // 3. asynchronous reset between edges
    @(posedge clk);
    #5;
    areset = 1'b0;
    #1;
    check("async_rst", {27'd0, c3, c2, c1, c0, locked}, 32'd0);

    // 5. hold reset with clock running
    for (int i = 0; i < 100; i++) begin
      tick();
      check("rst_hold", {27'd0, c3, c2, c1, c0, locked}, 32'd0);
    end
    check("dut2_rst", {27'd0, d3, d2, d1, d0, dlocked}, 32'd0);
    lock_seq("relock");
    for (int n = 1; n <= 10; n++) begin
      tick();
      check("relock_run", {28'd0, c3, c2, c1, c0}, {28'd0, ref_all(n, 2, 4, 5, 50)});
    end

    // 4. override build: DIV0=3, DIV3=2, LOCK_CYCLES=1
    @(negedge clk);
    areset2 = 1'b1;
    tick();
    check("ovr_lockedge", {27'd0, d3, d2, d1, d0, dlocked}, 32'h1f);
    for (int n = 1; n <= 12; n++) begin
      tick();
      check("ovr_run", {27'd0, d3, d2, d1, d0, dlocked},
            {27'd0, ref_all(n, 3, 4, 5, 2), 1'b1});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
